// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional per-requester beat counters are enabled with FIFO_ARB_STATS_EN.
module fifo_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_write_en,
  output logic [DATA_WIDTH-1:0]         fifo_in,
  output logic [IDW-1:0]                grant_id,
  output logic                          busy
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]         stat_beats
`endif
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);
  localparam logic [CW-1:0]  MAXB = CW'(MAX_BURST);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state, state_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [IDW-1:0] owner, owner_n;
  logic [CW-1:0]  beat_cnt, beat_cnt_n;
  logic [IDW-1:0] cand, idx;
  logic           cand_vld, accept;

  function automatic logic [IDW-1:0] nxt(input logic [IDW-1:0] x);
    return (x == LAST) ? '0 : x + 1'b1;
  endfunction

  // Highest-priority valid requester from rr_ptr; the owner alone during a burst
  always_comb begin
    cand_vld = 1'b0;
    cand     = rr_ptr;
    idx      = '0;
    if (state == BURST) begin
      cand_vld = 1'b1;
      cand     = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[idx]) begin
          cand_vld = 1'b1;
          cand     = idx;
        end
      end
    end
  end

  always_comb begin
    accept        = reset_n & cand_vld & req_valid[cand] & ~fifo_full;
    fifo_write_en = accept;
    req_ready     = accept ? (NUM_REQ'(1) << cand) : '0;
    fifo_in       = cand_vld ? req_data[int'(cand)*DATA_WIDTH +: DATA_WIDTH]
                             : '0;
    grant_id      = cand;
    busy          = (state == BURST);
  end

  always_comb begin
    state_n    = state;
    rr_ptr_n   = rr_ptr;
    owner_n    = owner;
    beat_cnt_n = beat_cnt;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (MAX_BURST == 1) begin
            rr_ptr_n = nxt(cand);
          end else begin
            state_n    = BURST;
            owner_n    = cand;
            beat_cnt_n = CW'(1);
          end
        end
      end
      BURST: begin
        if (!req_valid[owner]) begin
          state_n    = IDLE;
          rr_ptr_n   = nxt(owner);
          beat_cnt_n = '0;
        end else if (accept) begin
          if (beat_cnt + 1'b1 == MAXB) begin
            state_n    = IDLE;
            rr_ptr_n   = nxt(owner);
            beat_cnt_n = '0;
          end else begin
            beat_cnt_n = beat_cnt + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      rr_ptr   <= rr_ptr_n;
      owner    <= owner_n;
      beat_cnt <= beat_cnt_n;
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] beats [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) beats[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready[i] && beats[i] != 16'hFFFF)
          beats[i] <= beats[i] + 1'b1;
    end
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_beats[i*16 +: 16] = beats[i];
  end
`endif

endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write-side arbiter that shares the single write port of `synchronous_fifo` among `NUM_REQ` producers. It uses per-requester valid/ready handshakes and grants bounded bursts of up to `MAX_BURST` beats. It never writes while the FIFO reports `full`. It sits directly in front of the FIFO: its `fifo_write_en`/`fifo_in` outputs drive the FIFO's `write_en`/`in`, and the FIFO's `full` feeds back to it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `DATA_WIDTH`, 8: beat width; must match the FIFO.
- `MAX_BURST`, 4: maximum beats per grant, 1..16.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `req_valid` in `NUM_REQ`: requester i has a beat.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester i's data in slice `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: beat from requester i is accepted this cycle.
- `fifo_full` in 1: the FIFO's `full`.
- `fifo_write_en` out 1: goes to the FIFO's `write_en`.
- `fifo_in` out `DATA_WIDTH`: goes to the FIFO's `in`.
- `grant_id` out `$clog2(NUM_REQ)`: current or selected owner.
- `busy` out 1: burst in progress (state BURST).

## Operation
- Registered state:
  - `state` ∈ {IDLE, BURST}.
  - `rr_ptr`: next highest-priority requester.
  - `owner`.
  - `beat_cnt`, 0..`MAX_BURST`.
- IDLE selection:
  - Candidate is the first i with `req_valid[i]` scanning `rr_ptr`, `rr_ptr+1`, … modulo `NUM_REQ`.
  - No candidate → no grant; `grant_id` = `rr_ptr`.
- BURST selection: candidate is `owner` only; all other requesters are masked.
- Accept condition: accept = candidate exists & `req_valid[candidate]` & !`fifo_full`.
- Outputs on accept:
  - `req_ready[candidate]`=1 and `fifo_write_en`=1.
  - `fifo_in` = candidate's data slice.
  - All other `req_ready` bits = 0.
- Outputs without accept: `fifo_write_en`=0 and all `req_ready`=0. `fifo_in` is then don't-care; the implementation drives the candidate slice, or 0 when there is no candidate.
- IDLE transitions on accept of requester i:
  - If `MAX_BURST`==1: stay IDLE, `rr_ptr`←(i+1) mod `NUM_REQ`.
  - Otherwise: → BURST, `owner`←i, `beat_cnt`←1.
- BURST transitions:
  - Accept and `beat_cnt`+1 == `MAX_BURST` → IDLE, `rr_ptr`←(`owner`+1) mod `NUM_REQ`, `beat_cnt`←0.
  - Accept otherwise → `beat_cnt`←`beat_cnt`+1.
  - `req_valid[owner]`=0 → IDLE, `rr_ptr`←(`owner`+1) mod `NUM_REQ`, no write that cycle (one bubble).
  - `fifo_full`=1 with owner still valid → stall: hold state and `beat_cnt`; burst is not released.
- Fairness: every requester that stays valid is granted within `NUM_REQ`−1 bursts.
- Data ordering: beats from one requester enter the FIFO in request order; bursts from different requesters are never interleaved.

## Timing
- Accept is zero-latency: `req_ready`, `fifo_write_en` and `fifo_in` are combinational from `req_valid`, `fifo_full` and registered state. The beat is written at the same rising edge that completes the handshake.
- State, `rr_ptr`, `owner` and `beat_cnt` update on the rising edge only.
- Reset, sampled on a rising edge while `reset_n`=0:
  - `state`=IDLE, `rr_ptr`=0, `owner`=0, `beat_cnt`=0.
  - Resulting outputs: `busy`=0, `grant_id`=0, `fifo_write_en`=0, `req_ready`=0.
- Reset mid-burst aborts the burst; no write occurs in the reset cycle.
- `fifo_full` is honoured in the same cycle, so no write is ever issued while `full`=1.
- Full rises after the edge that writes the last slot; the next beat stalls.
- Simultaneous FIFO read and write are the FIFO's concern; the arbiter only observes `full`.
- `rr_ptr` wrap: `NUM_REQ`−1 → 0.

## Configuration
- Macro: `FIFO_ARB_STATS_EN`.
- When defined:
  - Adds output `stat_beats` (`NUM_REQ*16`): per-requester accepted-beat counters, 16 bits each.
  - Each counter increments on every accept of that requester and saturates at 16'hFFFF.
  - Counters clear on reset.
- When undefined: the port and the counters do not exist; the remaining behaviour is identical.

## Test plan
All scenarios use `NUM_REQ`=4, `MAX_BURST`=4, `DATA_WIDTH`=8 and an 8-deep FIFO draining after load unless noted.

- **Reset:** hold `reset_n`=0 for 2 edges with all `req_valid`=1. Required: `fifo_write_en`=0, `req_ready`=0, `busy`=0, `grant_id`=0 throughout.
- **Round-robin:** req0..3 valid continuously with data 8'h0k (k = requester); FIFO read every cycle. Required: FIFO output is four 8'h00, four 8'h01, four 8'h02, four 8'h03, then repeats from req0.
- **Early release:** req1 sends 2 beats (8'hA1, 8'hA2) then drops valid; req2 is valid. Required: one bubble cycle, then req2 is granted; `rr_ptr`=2 after release.
- **Full stall:** no reads; req0 valid with 10 beats 8'h10..8'h19. Required: exactly 8 writes, `full`=1, `req_ready`=0 while full. After one FIFO read, 8'h18 is written next, and the burst count continues correctly.
- **Mid-burst reset:** req3 is in BURST with `beat_cnt`=2, then `reset_n`=0 for one edge. Required: IDLE, `rr_ptr`=0, and req0 is granted first afterwards.
- **Stats (`FIFO_ARB_STATS_EN`):** run the round-robin scenario for 64 beats. Required: `stat_beats` = 16 for each requester.
